// File: rtl/sd_block_responder.sv
// Simulation-side SD block responder: serves 512-byte sector reads/writes for
// up to DRIVES mounted images from a byte-wide image memory port.
module sd_block_responder #(
  parameter int DRIVES    = 1,
  parameter int IMG_AW    = 24,
  parameter int ACK_DELAY = 4
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [32*DRIVES-1:0]  sd_lba,
  input  logic [DRIVES-1:0]     sd_rd,
  input  logic [DRIVES-1:0]     sd_wr,
  output logic [DRIVES-1:0]     sd_ack,
  output logic [8:0]            sd_buff_addr,
  output logic [7:0]            sd_buff_dout,
  output logic                  sd_buff_wr,
  input  logic [8*DRIVES-1:0]   sd_buff_din,
  input  logic [DRIVES-1:0]     mount_req,
  input  logic [63:0]           mount_size,
  output logic [DRIVES-1:0]     img_mounted,
  output logic [63:0]           img_size,
  output logic [3:0]            img_drive,
  output logic [IMG_AW-1:0]     img_addr,
  output logic                  img_rd,
  input  logic [7:0]            img_rdata,
  output logic                  img_wr,
  output logic [7:0]            img_wdata,
  output logic                  err
);

  // Only the lba bits that land inside one drive's image are kept for addressing.
  localparam int LW = IMG_AW - 9;
  localparam int CW = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ACK, S_RD, S_WR, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      drv_reg, drv_next;
  logic [LW-1:0]   lba_reg, lba_next;
  logic            oor_reg, oor_next;
  logic            wr_reg, wr_next;
  logic [CW-1:0]   ack_cnt_reg, ack_cnt_next;
  logic [8:0]      offset_reg, offset_next;
  logic            phase_reg, phase_next;
  logic            err_reg, err_next;
  logic [8:0]      hold_addr_reg;
  logic [DRIVES-1:0] img_mounted_reg;
  logic [63:0]     img_size_reg;
  logic [63:0]     size_reg [DRIVES];

  logic            req_any, sel_wr, sel_oor;
  logic [3:0]      sel_drv;
  logic [31:0]     sel_lba;
  logic [63:0]     sel_size, sel_need;
  logic [7:0]      din_sel;
  logic            busy, xfer, rd_a, rd_b, wr_b;

  // Fixed-priority scan: the descending loop lets the lowest index win.
  always_comb begin
    req_any  = 1'b0;
    sel_drv  = 4'd0;
    sel_wr   = 1'b0;
    sel_lba  = 32'd0;
    sel_size = 64'd0;
    for (int i = DRIVES - 1; i >= 0; i--) begin
      if (sd_rd[i] || sd_wr[i]) begin
        req_any  = 1'b1;
        sel_drv  = 4'(i);
        sel_wr   = !sd_rd[i];
        sel_lba  = sd_lba[i*32 +: 32];
        sel_size = size_reg[i];
      end
    end
    sel_need = ({32'd0, sel_lba} + 64'd1) << 9;
    sel_oor  = (sel_size == 64'd0) || (sel_need > sel_size);
  end

  always_comb begin
    din_sel = 8'd0;
    for (int i = 0; i < DRIVES; i++) begin
      if (drv_reg == 4'(i)) din_sel = sd_buff_din[i*8 +: 8];
    end
  end

  always_comb begin
    state_next   = state_reg;
    drv_next     = drv_reg;
    lba_next     = lba_reg;
    oor_next     = oor_reg;
    wr_next      = wr_reg;
    ack_cnt_next = ack_cnt_reg;
    offset_next  = offset_reg;
    phase_next   = phase_reg;
    err_next     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_any) begin
          drv_next     = sel_drv;
          lba_next     = sel_lba[LW-1:0];
          oor_next     = sel_oor;
          wr_next      = sel_wr;
          err_next     = sel_oor;
          ack_cnt_next = '0;
          offset_next  = 9'd0;
          phase_next   = 1'b0;
          state_next   = S_ACK;
        end
      end
      S_ACK: begin
        if (ack_cnt_reg == CW'(ACK_DELAY - 1)) state_next = wr_reg ? S_WR : S_RD;
        else ack_cnt_next = ack_cnt_reg + CW'(1);
      end
      S_RD, S_WR: begin
        phase_next = !phase_reg;
        if (phase_reg) begin
          if (offset_reg == 9'd511) state_next = S_DONE;
          else offset_next = offset_reg + 9'd1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_IDLE;
      drv_reg         <= 4'd0;
      lba_reg         <= '0;
      oor_reg         <= 1'b0;
      wr_reg          <= 1'b0;
      ack_cnt_reg     <= '0;
      offset_reg      <= 9'd0;
      phase_reg       <= 1'b0;
      err_reg         <= 1'b0;
      hold_addr_reg   <= 9'd0;
      img_mounted_reg <= '0;
      img_size_reg    <= 64'd0;
      for (int i = 0; i < DRIVES; i++) size_reg[i] <= 64'd0;
    end else begin
      state_reg       <= state_next;
      drv_reg         <= drv_next;
      lba_reg         <= lba_next;
      oor_reg         <= oor_next;
      wr_reg          <= wr_next;
      ack_cnt_reg     <= ack_cnt_next;
      offset_reg      <= offset_next;
      phase_reg       <= phase_next;
      err_reg         <= err_next;
      if (xfer) hold_addr_reg <= offset_reg;
      img_mounted_reg <= mount_req;
      if (|mount_req) img_size_reg <= mount_size;
      for (int i = 0; i < DRIVES; i++) begin
        if (mount_req[i]) size_reg[i] <= mount_size;
      end
    end
  end

  assign xfer = (state_reg == S_RD) || (state_reg == S_WR);
  assign busy = (state_reg == S_ACK) || xfer;
  assign rd_a = (state_reg == S_RD) && !phase_reg;
  assign rd_b = (state_reg == S_RD) && phase_reg;
  assign wr_b = (state_reg == S_WR) && phase_reg;

  for (genvar gi = 0; gi < DRIVES; gi++) begin : g_ack
    assign sd_ack[gi] = busy && (drv_reg == 4'(gi));
  end

  // Out-of-range transfers still run full length but never touch the image.
  assign sd_buff_addr = xfer ? offset_reg : hold_addr_reg;
  assign sd_buff_wr   = rd_b;
  assign sd_buff_dout = (rd_b && !oor_reg) ? img_rdata : 8'h00;
  assign img_rd       = rd_a && !oor_reg;
  assign img_wr       = wr_b && !oor_reg;
  assign img_wdata    = wr_b ? din_sel : 8'h00;
  assign img_addr     = {lba_reg, offset_reg};
  assign img_drive    = drv_reg;
  assign img_mounted  = img_mounted_reg;
  assign img_size     = img_size_reg;
  assign err          = err_reg;

endmodule

// File: doc/sd_block_responder.md
Name: sd_block_responder

Overview:
- Simulation-side responder for the MiSTer-style SD block interface driven by the track loaders (`sd_rd`/`sd_wr`/`sd_lba` in; `sd_ack`/`sd_buff_*` out).
- Serves 512-byte sector reads and writes for up to DRIVES mounted images, backed by a generic byte-wide image memory port.
- Generates the `img_mounted`/`img_size` mount notification.
- Sits in the Verilator top, replacing the HPS.

Parameters:
DRIVES, 1, number of drive request lines served (1..10)
IMG_AW, 24, byte-address width of one drive's image store
ACK_DELAY, 4, cycles between `sd_ack` rise and first buffer access (≥1)

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sd_lba  in  32*DRIVES  sector number per drive; drive i at bits [32i+31:32i]
sd_rd  in  DRIVES  read request level per drive
sd_wr  in  DRIVES  write request level per drive
sd_ack  out  DRIVES  transfer-in-progress per drive
sd_buff_addr  out  9  byte index within sector
sd_buff_dout  out  8  read data to initiator
sd_buff_wr  out  1  one-cycle strobe, `sd_buff_dout` valid
sd_buff_din  in  8*DRIVES  write data from initiator, valid 1 cycle after `sd_buff_addr`
mount_req  in  DRIVES  pulse: mount image on drive i
mount_size  in  64  image size in bytes, sampled with `mount_req`
img_mounted  out  DRIVES  one-cycle mount pulse
img_size  out  64  size of the last-mounted drive
img_drive  out  4  drive index for image access
img_addr  out  IMG_AW  byte address = {lba, offset} truncated to IMG_AW
img_rd  out  1  image read strobe; `img_rdata` valid next cycle
img_rdata  in  8  image read data
img_wr  out  1  image write strobe
img_wdata  out  8  image write data
err  out  1  one-cycle pulse on out-of-range access

Behaviour:
- Reset (async, `reset_n`=0): all outputs 0; state IDLE; all stored drive sizes 0 (unmounted). Mid-transfer reset abandons the sector; no partial flush.
- Mount:
  - `mount_req[i]` stores `mount_size` in `size[i]`.
  - Next cycle: `img_mounted[i]`=1 for one cycle and `img_size`=`mount_size`.
  - Allowed in any state. Affects range checks only for transfers starting after it.
- IDLE:
  - Scan drives in fixed priority, lowest index first. Requests are sampled only in IDLE and are level-sensitive.
  - `sd_rd` has priority over `sd_wr` on the same drive.
  - Latch drive, direction and `sd_lba[i]`.
  - Range check: `oor` = (`size[i]`==0) or ((`lba`+1)*512 > `size[i]`). If `oor`, pulse `err` in the ACK cycle.
  - Go to ACK.
- ACK:
  - `sd_ack[drv]`=1 from this cycle until DONE.
  - Wait ACK_DELAY cycles, then go to RD or WR. `offset`=0.
- RD, 2 cycles per byte:
  - Cycle A: `img_rd`=1 (suppressed if `oor`), `img_addr`={`lba`,`offset`}.
  - Cycle B: `sd_buff_dout`=`img_rdata` (0x00 if `oor`), `sd_buff_addr`=`offset`, `sd_buff_wr`=1. Increment `offset`.
  - After `offset` 511, go to DONE.
- WR, 2 cycles per byte:
  - Cycle A: `sd_buff_addr`=`offset`.
  - Cycle B: capture `sd_buff_din[drv]` into `img_wdata`; `img_wr`=1 (suppressed if `oor`) at `img_addr`={`lba`,`offset`}. Increment `offset`.
  - After byte 511, go to DONE.
- DONE:
  - Deassert `sd_ack`, one cycle, then IDLE.
  - A request still high in IDLE starts a new transfer; initiators drop `sd_rd`/`sd_wr` on seeing `sd_ack`.
- Between transfers: `sd_buff_addr` holds its last value. `sd_buff_wr`, `img_rd` and `img_wr` are 0 outside their strobe cycles.
- Addressing: `offset` is 9 bits and does not wrap within a transfer. `lba` bits above IMG_AW-9 are dropped from `img_addr` (the range check uses the full `lba`).
- Whole transfer: 1 + ACK_DELAY + 1024 + 1 cycles.

Test Plan:
- Mount drive 0, size 2048; image holds byte = offset^lba; `sd_rd[0]`=1, `sd_lba`=1 → `sd_ack[0]` high; 512 `sd_buff_wr` strobes, addr 0..511, dout = addr[7:0]^1; ack low 1+ACK_DELAY+1024 cycles after start; `err`=0.
- Write: `sd_wr[0]`, `lba`=2, size 2048; initiator buffer = ~addr → `img_wr` 512 times at `img_addr` 0x400..0x5FF with `img_wdata`=~offset[7:0].
- Out of range: `lba`=4, size 2048 → `err` pulse once; 512 strobes of dout 0x00; no `img_rd`.
- Unmounted write: no mount → `err` pulse; ack still completes; no `img_wr`.
- DRIVES=2, `sd_rd`=2'b11 at once → drive 0 served first (`sd_ack`=01), then `sd_ack`=10 after DONE; `img_drive` is 0 then 1.
- Reset asserted at byte 100 of a read → `sd_ack`, `sd_buff_wr`, `img_rd` go 0 immediately; after release, state IDLE with stored sizes cleared, so a new request pulses `err`.
